// File: rtl/gpio_intr_ctrl.sv
// ============================================================================
// gpio_intr_ctrl: GPIO pin synchronizer, edge/level event detector and pending latch.
// Optional debounce filter enabled by macro GPIO_DEBOUNCE_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module gpio_intr_ctrl #(
  parameter int NUM_PINS        = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NUM_PINS-1:0] r_data,
  input  logic [NUM_PINS-1:0] int_en,
  input  logic [NUM_PINS-1:0] rise_en,
  input  logic [NUM_PINS-1:0] fall_en,
  input  logic [NUM_PINS-1:0] level_mode,
  input  logic [NUM_PINS-1:0] level_pol,
  input  logic [NUM_PINS-1:0] clr,
  output logic [NUM_PINS-1:0] pin_sync,
  output logic [NUM_PINS-1:0] pending,
  output logic                interrupt
);

  logic [NUM_PINS-1:0] r_sync1;
  logic [NUM_PINS-1:0] r_sync2;
  logic [NUM_PINS-1:0] r_prev;
  logic [NUM_PINS-1:0] r_pending;
  logic [1:0]          r_prime;
  logic [NUM_PINS-1:0] w_filt;
  logic [NUM_PINS-1:0] w_rise;
  logic [NUM_PINS-1:0] w_fall;
  logic [NUM_PINS-1:0] w_level;
  logic [NUM_PINS-1:0] w_event;
  logic                w_primed;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= r_data;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    for (genvar i = 0; i < NUM_PINS; i++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_filt;

      // The filtered value flips on the edge where the count would reach DEBOUNCE_CYCLES.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (r_sync2[i] != r_filt) begin
          if (r_cnt == C_CNT_LAST) begin
            r_filt <= r_sync2[i];
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end

      assign w_filt[i] = r_filt;
    end
  endgenerate
`else
  assign w_filt = r_sync2;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_prev  <= '0;
      r_prime <= 2'd0;
    end else begin
      r_prev <= w_filt;
      if (r_prime != 2'd3) begin
        r_prime <= r_prime + 2'd1;
      end
    end
  end

  // Edges are held off until the synchronizer and prev register hold real pin data.
  assign w_primed = (r_prime == 2'd3);
  assign w_rise   = {NUM_PINS{w_primed}} & w_filt & ~r_prev & rise_en & ~level_mode;
  assign w_fall   = {NUM_PINS{w_primed}} & ~w_filt & r_prev & fall_en & ~level_mode;
  assign w_level  = level_mode & ~(w_filt ^ level_pol);
  assign w_event  = w_rise | w_fall | w_level;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~clr) | w_event;
    end
  end

  assign pin_sync  = w_filt;
  assign pending   = r_pending;
  assign interrupt = |(r_pending & int_en);

endmodule

`default_nettype wire

// File: tb/tb_gpio_intr_ctrl.sv
// ============================================================================
// tb_gpio_intr_ctrl: directed vector bench for gpio_intr_ctrl.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_gpio_intr_ctrl;

`ifdef GPIO_DEBOUNCE_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 0;
`endif

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] r_data, int_en, rise_en, fall_en, level_mode, level_pol, clr;
  logic [7:0] pin_sync, pending;
  logic       interrupt;

  int checks   = 0;
  int failures = 0;

  gpio_intr_ctrl #(.NUM_PINS(8), .DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK), .nRST(nRST), .r_data(r_data), .int_en(int_en), .rise_en(rise_en),
    .fall_en(fall_en), .level_mode(level_mode), .level_pol(level_pol), .clr(clr),
    .pin_sync(pin_sync), .pending(pending), .interrupt(interrupt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] r, ie, re, fe, lm, lp, cl;
    int         n;
    bit         lat;
    logic [7:0] e_sync, e_pend;
    logic       e_irq;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_clr(input logic [7:0] m);
    clr = m;
    @(negedge CLK);
    clr = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // r, ie, re, fe, lm, lp, cl, n, lat, e_sync, e_pend, e_irq
    vecs[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 2, 1'b1, 8'h08, 8'h00, 1'b0};
    vecs[2]  = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b0, 8'h08, 8'h08, 1'b1};
    vecs[3]  = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h08, 1, 1'b0, 8'h08, 8'h00, 1'b0};
    vecs[4]  = '{8'h28, 8'h08, 8'h08, 8'h20, 8'h00, 8'h00, 8'h00, 3, 1'b1, 8'h28, 8'h00, 1'b0};
    vecs[5]  = '{8'h08, 8'h08, 8'h08, 8'h20, 8'h00, 8'h00, 8'h00, 3, 1'b1, 8'h08, 8'h20, 1'b0};
    vecs[6]  = '{8'h08, 8'h28, 8'h08, 8'h20, 8'h00, 8'h00, 8'h00, 0, 1'b0, 8'h08, 8'h20, 1'b1};
    vecs[7]  = '{8'h08, 8'h28, 8'h08, 8'h20, 8'h00, 8'h00, 8'h20, 1, 1'b0, 8'h08, 8'h00, 1'b0};
    vecs[8]  = '{8'h08, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 1, 1'b0, 8'h08, 8'h01, 1'b1};
    vecs[9]  = '{8'h08, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 1, 1'b0, 8'h08, 8'h01, 1'b1};
    vecs[10] = '{8'h09, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 3, 1'b1, 8'h09, 8'h01, 1'b1};
    vecs[11] = '{8'h09, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 1, 1'b0, 8'h09, 8'h00, 1'b0};
    vecs[12] = '{8'h0D, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 2, 1'b1, 8'h0D, 8'h00, 1'b0};
    vecs[13] = '{8'h0D, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 1, 1'b0, 8'h0D, 8'h04, 1'b1};
    vecs[14] = '{8'h0D, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 1, 1'b0, 8'h0D, 8'h00, 1'b0};

    nRST = 1'b0;
    r_data = 8'hFF; int_en = 8'hFF; rise_en = 8'hFF;
    fall_en = '0; level_mode = '0; level_pol = '0; clr = '0;

    repeat (2) @(negedge CLK);
    check("reset_pin_sync", pin_sync, 8'h00);
    check("reset_pending", pending, 8'h00);
    check("reset_interrupt", interrupt, 1'b0);

    nRST = 1'b1;
    repeat (2 + EXTRA) @(negedge CLK);
    check("prime_pin_sync", pin_sync, 8'hFF);
    repeat (4) @(negedge CLK);
`ifndef GPIO_DEBOUNCE_EN
    check("prime_pending", pending, 8'h00);
    check("prime_interrupt", interrupt, 1'b0);
`endif
    pulse_clr(8'hFF);

    for (int i = 0; i < 15; i++) begin
      r_data = vecs[i].r; int_en = vecs[i].ie; rise_en = vecs[i].re; fall_en = vecs[i].fe;
      level_mode = vecs[i].lm; level_pol = vecs[i].lp; clr = vecs[i].cl;
      if (vecs[i].n == 0) begin
        #1;
      end else begin
        @(negedge CLK);
        clr = '0;
        repeat (vecs[i].n - 1 + (vecs[i].lat ? EXTRA : 0)) @(negedge CLK);
      end
      check($sformatf("vec%0d_pin_sync", i), pin_sync, vecs[i].e_sync);
      check($sformatf("vec%0d_pending", i), pending, vecs[i].e_pend);
      check($sformatf("vec%0d_interrupt", i), interrupt, vecs[i].e_irq);
    end

`ifndef GPIO_DEBOUNCE_EN
    // Asynchronous reset mid-cycle, then re-prime with pins held high.
    rise_en = 8'hFF; int_en = 8'hFF; r_data = 8'h0F;
    repeat (3) @(negedge CLK);
    check("midrst_before_pending", pending, 8'h02);
    #2 nRST = 1'b0;
    #1;
    check("midrst_async_pending", pending, 8'h00);
    check("midrst_async_interrupt", interrupt, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (6) @(negedge CLK);
    check("midrst_reprime_pending", pending, 8'h00);
    check("midrst_reprime_sync", pin_sync, 8'h0F);
`else
    rise_en = 8'h02; int_en = 8'h02; fall_en = '0; level_mode = '0; r_data = 8'h00;
    repeat (10) @(negedge CLK);
    pulse_clr(8'hFF);
    r_data = 8'h02;
    repeat (3) @(negedge CLK);
    r_data = 8'h00;
    repeat (12) @(negedge CLK);
    check("db_short_pulse_pending", pending, 8'h00);
    check("db_short_pulse_sync", pin_sync, 8'h00);
    r_data = 8'h02;
    repeat (6) @(negedge CLK);
    check("db_long_before_pending", pending, 8'h00);
    r_data = 8'h00;
    @(negedge CLK);
    check("db_long_pending", pending, 8'h02);
    check("db_long_interrupt", interrupt, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
